mlp_layer_seq: RTL and testbench

//  Parametrised control sequencer for an N-layer MLP inference engine on Basys3.

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/mlp_layer_seq_delay.sv | 27 ++
 rtl/mlp_layer_seq.sv | 155 +++++++++++++++
 tb/tb_mlp_layer_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer: state encoding and default layer geometry.
package mlp_pkg;

    localparam int unsigned DEF_NUM_LAYERS = 2;
    localparam int unsigned DEF_LEN_W      = 10;
    localparam logic [DEF_NUM_LAYERS*DEF_LEN_W-1:0] DEF_LAYER_LEN = {10'd32, 10'd784};

    // Width of the dwell counter used for LOAD/DRAIN/ACT/ARGMAX durations
    localparam int unsigned CNT_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_ACT,
        S_ARGMAX,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mlp_layer_seq_delay.sv
// Fixed-depth shift register with synchronous clear; aligns mac_en with the memory read latency.
module seq_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sh <= '0;
        end else begin
            r_sh[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    assign o_q = r_sh[DEPTH-1];

endmodule

// File: rtl/mlp_layer_seq.sv
// Control sequencer for a layered MLP inference engine: walks a shared MAC datapath through
// load, bias-clear, input streaming, drain and activation per layer, then argmax per image.
module mlp_layer_seq
    import mlp_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter logic [NUM_LAYERS*LEN_W-1:0] LAYER_LEN = DEF_LAYER_LEN,
    parameter int unsigned PIPE_LAT   = 1,
    parameter int unsigned LOAD_CYC   = 2,
    parameter int unsigned ACT_CYC    = 2,
    parameter int unsigned LAYER_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         num_imgs,
    output logic               busy,
    output logic               load_img,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               mac_clr,
    output logic [LEN_W-1:0]   addr,
    output logic               addr_vld,
    output logic               mac_en,
    output logic               act_en,
    output logic               find_max,
    output logic               img_done,
    output logic [7:0]         img_idx,
    output logic               done,
    output logic               aborted
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_addr;
    logic [LAYER_W-1:0] r_layer;
    logic [7:0]         r_img;
    logic [7:0]         r_num;
    logic               r_aborted;

    logic [LEN_W-1:0]   w_len;
    logic               w_run_last;
    logic               w_last_layer;
    logic               w_last_img;
    logic               w_abort;
    logic               w_mac_en;

    always_comb begin
        w_len        = LAYER_LEN[int'(r_layer)*LEN_W +: LEN_W];
        w_run_last   = (r_addr == w_len - 1'b1);
        w_last_layer = (r_layer == LAYER_W'(NUM_LAYERS - 1));
        w_last_img   = (r_img == r_num - 8'd1);
        w_abort      = abort && (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks start, so abort+start in IDLE stays in IDLE
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_LOAD;
                S_LOAD:   if (r_cnt == CNT_W'(LOAD_CYC - 1)) w_next = S_CLR;
                S_CLR:    w_next = S_RUN;
                S_RUN:    if (w_run_last) w_next = S_DRAIN;
                S_DRAIN:  if (r_cnt == CNT_W'(PIPE_LAT - 1))
                              w_next = w_last_layer ? S_ARGMAX : S_ACT;
                S_ACT:    if (r_cnt == CNT_W'(ACT_CYC - 1)) w_next = S_CLR;
                S_ARGMAX: if (r_cnt == CNT_W'(1)) w_next = S_NEXT;
                S_NEXT:   w_next = w_last_img ? S_DONE : S_LOAD;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_layer   <= '0;
            r_img     <= '0;
            r_num     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
            if (w_abort) begin
                r_cnt   <= '0;
                r_addr  <= '0;
                r_layer <= '0;
                r_img   <= '0;
            end else begin
                // Dwell counter idles at zero in IDLE and RUN so it can never wrap
                if (w_next != r_state || r_state == S_IDLE || r_state == S_RUN)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + 1'b1;

                if (r_state == S_CLR)
                    r_addr <= '0;
                else if (r_state == S_RUN && !w_run_last)
                    r_addr <= r_addr + 1'b1;

                if (r_state == S_IDLE && w_next == S_LOAD) begin
                    r_layer <= '0;
                    r_img   <= '0;
                    r_num   <= (num_imgs == 8'd0) ? 8'd1 : num_imgs;
                end else if (r_state == S_ACT && w_next == S_CLR) begin
                    r_layer <= r_layer + 1'b1;
                end else if (r_state == S_NEXT && !w_last_img) begin
                    r_layer <= '0;
                    r_img   <= r_img + 8'd1;
                end
            end
        end
    end

    seq_delay #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_abort),
        .i_d   (r_state == S_RUN),
        .o_q   (w_mac_en)
    );

    always_comb begin
        busy      = (r_state != S_IDLE);
        load_img  = (r_state == S_LOAD) && (r_cnt == '0);
        layer_idx = r_layer;
        mac_clr   = (r_state == S_CLR);
        addr      = r_addr;
        addr_vld  = (r_state == S_RUN);
        mac_en    = w_mac_en;
        act_en    = (r_state == S_ACT) && (r_cnt == '0);
        find_max  = (r_state == S_ARGMAX) && (r_cnt == '0);
        img_done  = (r_state == S_NEXT);
        img_idx   = r_img;
        done      = (r_state == S_DONE);
        aborted   = r_aborted;
    end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Directed bench for mlp_layer_seq: default timeline table, batch, abort, restart,
// deeper pipeline and single-layer variants.
module tb_mlp_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic [7:0] num_imgs;
    logic       busy, load_img, mac_clr, addr_vld, mac_en, act_en, find_max, img_done, done, aborted;
    logic [1:0] layer_idx;
    logic [9:0] addr;
    logic [7:0] img_idx;

    logic       start_b, start_c, abort_bc;
    logic [7:0] num_bc;
    logic       busy_b, load_img_b, mac_clr_b, addr_vld_b, mac_en_b, act_en_b, find_max_b;
    logic       img_done_b, done_b, aborted_b;
    logic [1:0] layer_idx_b;
    logic [9:0] addr_b;
    logic [7:0] img_idx_b;
    logic       busy_c, load_img_c, mac_clr_c, addr_vld_c, mac_en_c, act_en_c, find_max_c;
    logic       img_done_c, done_c, aborted_c;
    logic [0:0] layer_idx_c;
    logic [9:0] addr_c;
    logic [7:0] img_idx_c;

    mlp_layer_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_imgs(num_imgs),
        .busy(busy), .load_img(load_img), .layer_idx(layer_idx), .mac_clr(mac_clr),
        .addr(addr), .addr_vld(addr_vld), .mac_en(mac_en), .act_en(act_en),
        .find_max(find_max), .img_done(img_done), .img_idx(img_idx), .done(done),
        .aborted(aborted)
    );

    mlp_layer_seq #(
        .PIPE_LAT  (3),
        .LAYER_LEN ({10'd4, 10'd8})
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_bc), .num_imgs(num_bc),
        .busy(busy_b), .load_img(load_img_b), .layer_idx(layer_idx_b), .mac_clr(mac_clr_b),
        .addr(addr_b), .addr_vld(addr_vld_b), .mac_en(mac_en_b), .act_en(act_en_b),
        .find_max(find_max_b), .img_done(img_done_b), .img_idx(img_idx_b), .done(done_b),
        .aborted(aborted_b)
    );

    mlp_layer_seq #(
        .NUM_LAYERS (1),
        .LAYER_LEN  (10'd5),
        .LAYER_W    (1)
    ) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_bc), .num_imgs(num_bc),
        .busy(busy_c), .load_img(load_img_c), .layer_idx(layer_idx_c), .mac_clr(mac_clr_c),
        .addr(addr_c), .addr_vld(addr_vld_c), .mac_en(mac_en_c), .act_en(act_en_c),
        .find_max(find_max_c), .img_done(img_done_c), .img_idx(img_idx_c), .done(done_c),
        .aborted(aborted_c)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // strobe bits: busy load_img mac_clr addr_vld mac_en act_en find_max img_done done
    typedef struct {
        int         t;
        logic [8:0] st;
        logic [9:0] a;
        logic [1:0] l;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    logic [8:0] w_st;
    int n_men, n_act, n_fmax, n_idone, n_done, done_t, first_t, last_t, bad, n_l0, n_l1;
    int idone_t[4];
    int idone_idx[4];
    logic vb[0:31];
    logic mb[0:31];

    initial begin
        tbl[0]  = '{1,   9'b110000000, 10'd0,   2'd0};
        tbl[1]  = '{2,   9'b100000000, 10'd0,   2'd0};
        tbl[2]  = '{3,   9'b101000000, 10'd0,   2'd0};
        tbl[3]  = '{4,   9'b100100000, 10'd0,   2'd0};
        tbl[4]  = '{5,   9'b100110000, 10'd1,   2'd0};
        tbl[5]  = '{787, 9'b100110000, 10'd783, 2'd0};
        tbl[6]  = '{788, 9'b100010000, 10'd783, 2'd0};
        tbl[7]  = '{789, 9'b100001000, 10'd783, 2'd0};
        tbl[8]  = '{790, 9'b100000000, 10'd783, 2'd0};
        tbl[9]  = '{791, 9'b101000000, 10'd783, 2'd1};
        tbl[10] = '{792, 9'b100100000, 10'd0,   2'd1};
        tbl[11] = '{793, 9'b100110000, 10'd1,   2'd1};
        tbl[12] = '{823, 9'b100110000, 10'd31,  2'd1};
        tbl[13] = '{824, 9'b100010000, 10'd31,  2'd1};
        tbl[14] = '{825, 9'b100000100, 10'd31,  2'd1};
        tbl[15] = '{826, 9'b100000000, 10'd31,  2'd1};
        tbl[16] = '{827, 9'b100000010, 10'd31,  2'd1};
        tbl[17] = '{828, 9'b100000001, 10'd31,  2'd1};
        tbl[18] = '{829, 9'b000000000, 10'd31,  2'd1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; num_imgs = 8'd1;
        start_b = 1'b0; start_c = 1'b0; abort_bc = 1'b0; num_bc = 8'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w_st = {busy, load_img, mac_clr, addr_vld, mac_en, act_en, find_max, img_done, done};
        chk("reset_strobes", {23'd0, w_st}, 32'd0);
        chk("reset_addr", {22'd0, addr}, 32'd0);
        chk("reset_misc", {22'd0, layer_idx, img_idx}, 32'd0);
        chk("reset_aborted", {31'd0, aborted}, 32'd0);

        // single image, default timeline
        num_imgs = 8'd1; start = 1'b1;
        n_men = 0; n_act = 0; n_fmax = 0;
        for (int t = 1; t <= 829; t++) begin
            @(negedge clk);
            start = 1'b0;
            w_st = {busy, load_img, mac_clr, addr_vld, mac_en, act_en, find_max, img_done, done};
            if (mac_en) n_men++;
            if (act_en) n_act++;
            if (find_max) n_fmax++;
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].t == t) begin
                    chk($sformatf("t%0d_strobes", t), {23'd0, w_st}, {23'd0, tbl[i].st});
                    chk($sformatf("t%0d_addr", t), {22'd0, addr}, {22'd0, tbl[i].a});
                    chk($sformatf("t%0d_layer", t), {30'd0, layer_idx}, {30'd0, tbl[i].l});
                end
            end
        end
        chk("mac_en_total", n_men, 816);
        chk("act_en_total", n_act, 1);
        chk("find_max_total", n_fmax, 1);

        // batch of three images
        num_imgs = 8'd3; start = 1'b1;
        n_idone = 0; n_done = 0; done_t = -1;
        for (int t = 1; t <= 2490; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (img_done) begin
                if (n_idone < 4) begin
                    idone_t[n_idone]   = t;
                    idone_idx[n_idone] = int'(img_idx);
                end
                n_idone++;
            end
            if (done) begin n_done++; done_t = t; end
        end
        chk("batch_img_done_count", n_idone, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < n_idone) begin
                chk($sformatf("batch_img_done%0d_cycle", i), idone_t[i], 827 * (i + 1));
                chk($sformatf("batch_img_done%0d_idx", i), idone_idx[i], i);
            end
        end
        chk("batch_done_count", n_done, 1);
        chk("batch_done_cycle", done_t, 2482);

        // abort during layer 0 RUN
        num_imgs = 8'd1; start = 1'b1;
        for (int t = 1; t <= 402; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 400) begin
                chk("abort_pre_busy_men", {30'd0, busy, mac_en}, 32'd3);
                abort = 1'b1;
            end
            if (t == 401) begin
                abort = 1'b0;
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_pulse", {31'd0, aborted}, 32'd1);
                chk("abort_mac_en", {31'd0, mac_en}, 32'd0);
            end
            if (t == 402) chk("abort_pulse_width", {31'd0, aborted}, 32'd0);
        end
        n_idone = 0; n_done = 0;
        for (int t = 0; t < 900; t++) begin
            @(negedge clk);
            if (img_done) n_idone++;
            if (done) n_done++;
            if (busy) n_done++;
        end
        chk("abort_no_done", n_idone + n_done, 0);

        // abort together with start in IDLE
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("idle_abort_wins", {30'd0, busy, aborted}, 32'd0);

        // start held high, num_imgs 0 treated as one
        num_imgs = 8'd0; start = 1'b1;
        n_idone = 0; n_done = 0; done_t = -1;
        for (int t = 1; t <= 830; t++) begin
            @(negedge clk);
            if (img_done) n_idone++;
            if (done) begin n_done++; done_t = t; end
            if (t == 829) chk("held_idle_busy", {31'd0, busy}, 32'd0);
            if (t == 830) chk("held_restart_load", {30'd0, busy, load_img}, 32'd3);
        end
        chk("held_one_image", n_idone, 1);
        chk("held_done_cycle", done_t, 828);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // reset mid-operation
        num_imgs = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {29'd0, busy, aborted, mac_en}, 32'd0);

        // PIPE_LAT=3, layer lengths 8 then 4
        start_b = 1'b1;
        vb[0] = 1'b0; mb[0] = 1'b0;
        n_l0 = 0; n_l1 = 0; first_t = -1; last_t = -1; done_t = -1;
        for (int t = 1; t <= 31; t++) begin
            @(negedge clk);
            start_b = 1'b0;
            vb[t] = addr_vld_b;
            mb[t] = mac_en_b;
            if (mac_en_b) begin
                if (first_t < 0) first_t = t;
                last_t = t;
                if (layer_idx_b == 2'd0) n_l0++; else n_l1++;
            end
            if (done_b) done_t = t;
        end
        bad = 0;
        for (int t = 3; t <= 31; t++) if (mb[t] !== vb[t-3]) bad++;
        chk("lat3_lag_errors", bad, 0);
        chk("lat3_first_mac_en", first_t, 7);
        chk("lat3_last_mac_en", last_t, 24);
        chk("lat3_layer0_count", n_l0, 8);
        chk("lat3_layer1_count", n_l1, 4);
        chk("lat3_done_cycle", done_t, 28);

        // single-layer network
        start_c = 1'b1;
        n_act = 0; n_men = 0; first_t = -1; done_t = -1; last_t = -1;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            start_c = 1'b0;
            if (act_en_c) n_act++;
            if (mac_en_c) begin n_men++; last_t = t; end
            if (find_max_c) first_t = t;
            if (done_c) done_t = t;
        end
        chk("one_layer_no_act", n_act, 0);
        chk("one_layer_mac_en_count", n_men, 5);
        chk("one_layer_last_mac_en", last_t, 9);
        chk("one_layer_find_max", first_t, 10);
        chk("one_layer_done", done_t, 13);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
